// File: rtl/control_partida.sv
// Match sequencer for the two-player LED game: paces countdown, play and result
// display on a slow tick, keeps both scores and latches the match winner.
module control_partida #(
    parameter int PUNTOS_GANAR   = 3,
    parameter int ANCHO          = 2,
    parameter int CICLOS_CUENTA  = 3,
    parameter int CICLOS_MUESTRA = 2
) (
    input  logic             clk,
    input  logic             resetTotal,
    input  logic             tick,
    input  logic             inicio,
    input  logic             Apagar,
    input  logic             GanadorA,
    input  logic             GanadorB,
    output logic             resetContador,
    output logic             habilitarJuego,
    output logic [ANCHO-1:0] marcadorA,
    output logic [ANCHO-1:0] marcadorB,
    output logic             partidaA,
    output logic             partidaB,
    output logic [2:0]       estado
);

    localparam logic [2:0] APAGADO = 3'd0;
    localparam logic [2:0] ESPERA  = 3'd1;
    localparam logic [2:0] CUENTA  = 3'd2;
    localparam logic [2:0] JUEGO   = 3'd3;
    localparam logic [2:0] PUNTO   = 3'd4;
    localparam logic [2:0] FIN     = 3'd5;

    localparam logic [ANCHO-1:0] META      = ANCHO'(PUNTOS_GANAR);
    localparam logic [ANCHO-1:0] UNO       = ANCHO'(1);
    localparam logic [7:0]       T_CUENTA  = 8'(CICLOS_CUENTA);
    localparam logic [7:0]       T_MUESTRA = 8'(CICLOS_MUESTRA);

    logic [2:0]       state, state_next;
    logic [7:0]       timer, timer_next;
    logic [ANCHO-1:0] marcador_a_next, marcador_b_next;
    logic             partida_a_next, partida_b_next;

    always_ff @(posedge clk or posedge resetTotal) begin
        if (resetTotal) begin
            state     <= ESPERA;
            timer     <= 8'd0;
            marcadorA <= '0;
            marcadorB <= '0;
            partidaA  <= 1'b0;
            partidaB  <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            marcadorA <= marcador_a_next;
            marcadorB <= marcador_b_next;
            partidaA  <= partida_a_next;
            partidaB  <= partida_b_next;
        end
    end

    // Timer stops at 1: the expiring tick changes state instead of decrementing.
    always_comb begin
        state_next      = state;
        timer_next      = timer;
        marcador_a_next = marcadorA;
        marcador_b_next = marcadorB;
        partida_a_next  = partidaA;
        partida_b_next  = partidaB;
        if (Apagar) begin
            state_next      = APAGADO;
            marcador_a_next = '0;
            marcador_b_next = '0;
            partida_a_next  = 1'b0;
            partida_b_next  = 1'b0;
        end else begin
            case (state)
                APAGADO: state_next = ESPERA;
                ESPERA, FIN: begin
                    if (inicio) begin
                        state_next      = CUENTA;
                        timer_next      = T_CUENTA;
                        marcador_a_next = '0;
                        marcador_b_next = '0;
                        partida_a_next  = 1'b0;
                        partida_b_next  = 1'b0;
                    end
                end
                CUENTA: begin
                    if (tick) begin
                        if (timer <= 8'd1) state_next = JUEGO;
                        else               timer_next = timer - 8'd1;
                    end
                end
                JUEGO: begin
                    if (GanadorA || GanadorB) begin
                        state_next = PUNTO;
                        timer_next = T_MUESTRA;
                        if (GanadorA && !GanadorB) marcador_a_next = marcadorA + UNO;
                        if (GanadorB && !GanadorA) marcador_b_next = marcadorB + UNO;
                    end
                end
                PUNTO: begin
                    if (tick) begin
                        if (timer <= 8'd1) begin
                            if (marcadorA == META) begin
                                state_next     = FIN;
                                partida_a_next = 1'b1;
                            end else if (marcadorB == META) begin
                                state_next     = FIN;
                                partida_b_next = 1'b1;
                            end else begin
                                state_next = CUENTA;
                                timer_next = T_CUENTA;
                            end
                        end else begin
                            timer_next = timer - 8'd1;
                        end
                    end
                end
                default: state_next = ESPERA;
            endcase
        end
    end

    // Counter runs only in JUEGO; in PUNTO it is frozen (not reset) to keep the result visible.
    always_comb begin
        resetContador  = 1'b1;
        habilitarJuego = 1'b0;
        case (state)
            JUEGO: begin
                resetContador  = 1'b0;
                habilitarJuego = 1'b1;
            end
            PUNTO:   resetContador = 1'b0;
            default: ;
        endcase
    end

    assign estado = state;

endmodule

// File: doc/control_partida.md
Name: control_partida

Overview:
Match sequencer for the two-player LED game.
- Sequences the round datapath: holds the game counter in reset during idle and countdown, enables play, and scores each round from the GanadorA/GanadorB flags.
- Declares a match winner after PUNTOS_GANAR points.
- Sits between the game counter/ResetJuego logic and the board buttons/LEDs; all timing is paced by a slow tick enable.

Parameters:
- PUNTOS_GANAR, 3, points needed to win a match; legal range 1..2^ANCHO-1.
- ANCHO, 2, width of each score register.
- CICLOS_CUENTA, 3, ticks spent in countdown before play; legal range 1..255.
- CICLOS_MUESTRA, 2, ticks the round result is shown; legal range 1..255.

Ports:
- clk, input, 1, system clock, rising edge.
- resetTotal, input, 1, asynchronous active-high reset.
- tick, input, 1, one-clk-wide timebase enable from the prescaler.
- inicio, input, 1, start pulse, one clk wide, already debounced.
- Apagar, input, 1, power-off request, level.
- GanadorA, input, 1, round-won flag from the datapath for player A, level.
- GanadorB, input, 1, round-won flag from the datapath for player B, level.
- resetContador, output, 1, holds the game counter in reset.
- habilitarJuego, output, 1, enables the game counter and buttons.
- marcadorA, output, ANCHO, player A score.
- marcadorB, output, ANCHO, player B score.
- partidaA, output, 1, player A won the match (held).
- partidaB, output, 1, player B won the match (held).
- estado, output, 3, current state code, for debug LEDs.

Behaviour:
- Clock and reset:
  - Single clock domain; resetTotal is asynchronous, active-high.
  - On reset: state=ESPERA, timer=0, marcadorA=marcadorB=0, partidaA=partidaB=0.
- Output decode:
  - All outputs are decoded from registered state/score, so they are glitch-free.
  - Every output changes in the cycle after the clk edge that changes state.
- State codes: APAGADO=0, ESPERA=1, CUENTA=2, JUEGO=3, PUNTO=4, FIN=5. Codes 6 and 7 are illegal and go to ESPERA on the next edge.
- Apagar (highest priority):
  - From any state, Apagar=1 -> APAGADO on the next edge.
  - In APAGADO: resetContador=1, habilitarJuego=0, scores and partida flags cleared.
  - APAGADO -> ESPERA on the first edge with Apagar=0.
- ESPERA:
  - resetContador=1, habilitarJuego=0.
  - inicio=1 -> CUENTA; load timer=CICLOS_CUENTA; clear scores and partida flags.
  - A tick in the same cycle as inicio is ignored.
- CUENTA:
  - resetContador=1, habilitarJuego=0.
  - Each tick decrements the timer.
  - tick with timer==1 -> JUEGO.
- JUEGO:
  - resetContador=0, habilitarJuego=1.
  - GanadorA=1 and GanadorB=0 -> marcadorA+1; go to PUNTO.
  - GanadorB=1 and GanadorA=0 -> marcadorB+1; go to PUNTO.
  - Both=1 in the same cycle -> tie: no score change; go to PUNTO (round is replayed).
  - Every transition to PUNTO loads timer=CICLOS_MUESTRA.
  - inicio and tick are ignored.
  - GanadorA/B are sampled only in JUEGO.
- PUNTO:
  - resetContador=0, habilitarJuego=0; the counter is frozen so the result stays displayed.
  - tick decrements the timer. On tick with timer==1:
    - marcadorA==PUNTOS_GANAR -> FIN with partidaA=1.
    - else marcadorB==PUNTOS_GANAR -> FIN with partidaB=1.
    - else -> CUENTA with timer=CICLOS_CUENTA.
- FIN:
  - resetContador=1, habilitarJuego=0; scores and partida flag held.
  - inicio -> CUENTA; clear scores and flags; load timer=CICLOS_CUENTA.
- Score arithmetic:
  - Scores never exceed PUNTOS_GANAR, so there is no wrap.
  - partidaA and partidaB are mutually exclusive.
- The timer is 8-bit and is never decremented below 1.

Test Plan:
- Reset mid-JUEGO (assert resetTotal asynchronously) -> estado=1, marcadores=0, resetContador=1 immediately, without waiting for a clk edge.
- Defaults:
  - inicio pulse, then 3 ticks -> estado=2 for exactly 3 ticks, then estado=3 with habilitarJuego=1, resetContador=0.
  - GanadorA pulse -> estado=4, marcadorA=1.
- Tie: in JUEGO, GanadorA=GanadorB=1 in the same cycle -> marcadorA=marcadorB=0; PUNTO for 2 ticks, then CUENTA.
- Full match: A wins 3 rounds, B wins 1 -> after the third A point plus 2 ticks, estado=5, partidaA=1, partidaB=0, marcadorA=3, marcadorB=1. A subsequent inicio -> scores 0, estado=2.
- Apagar=1 asserted in PUNTO with marcadorB=2 -> estado=0 next edge, scores 0. Release Apagar -> estado=1. tick/inicio ignored while Apagar=1.
- Boundary: inicio and tick in the same cycle in ESPERA -> the countdown still lasts 3 full ticks. Sweep GanadorA/GanadorB over all 4 combinations in every state -> score changes only in JUEGO.
